// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-side drain stage that sits directly behind a sync_fifo. It pops
// WIDTH-bit words using the FIFO's rd_en/rd_empty/rd_data interface (one
// cycle read latency), packs RATIO consecutive words into one wide beat and
// presents that beat on a valid/ready stream. A flush pulse forces out a
// partial beat so tail data never strands in the packer.
//
// Parameters
//   WIDTH  FIFO word width (must match the sync_fifo instance)
//   RATIO  words per output beat (>= 2)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   rd_empty   FIFO empty flag
//   rd_data    FIFO read data, valid the cycle after rd_en is sampled high
//   rd_en      FIFO pop request
//   flush      single-cycle pulse: emit whatever is packed
//   out_data   packed beat, first-popped word in bits [WIDTH-1:0]
//   out_cnt    number of valid words in out_data (1..RATIO)
//   out_valid  beat available
//   out_ready  downstream accepts beat
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
   parameter int WIDTH = 4,
   parameter int RATIO = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             rd_empty,
   input  logic [WIDTH-1:0]                 rd_data,
   output logic                             rd_en,
   input  logic                             flush,
   output logic [WIDTH*RATIO-1:0]           out_data,
   output logic [$clog2(RATIO+1)-1:0]       out_cnt,
   output logic                             out_valid,
   input  logic                             out_ready
);

   localparam int OUT_W = WIDTH * RATIO;
   localparam int CNT_W = $clog2(RATIO + 1);

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t             state;
   logic [OUT_W-1:0]   acc;         // packing register, slot i at [i*WIDTH +: WIDTH]
   logic [CNT_W-1:0]   acc_cnt;     // words already captured into acc
   logic               inflight;    // a pop was issued last cycle, rd_data is live now

   logic [CNT_W-1:0]   acc_sum;     // words captured plus the one landing this edge
   logic [OUT_W-1:0]   acc_merged;  // acc with this edge's rd_data already placed
   logic               group_done;
   logic               out_free;
   logic               flush_emit;

   // Credit count: a pop in flight already owns a slot, so it counts against
   // the RATIO slots of storage before the next pop is allowed.
   assign acc_sum    = acc_cnt + CNT_W'(inflight);
   assign group_done = (acc_sum == CNT_W'(RATIO));

   // The output register can take a new beat if it is empty or is being
   // consumed on this very edge.
   assign out_free   = !out_valid || out_ready;

   // Partial emit in FLUSH once nothing is in flight and the output is free;
   // a full group takes priority and is handled by the normal hand-off.
   assign flush_emit = (state == FLUSH) && !inflight && out_free && !group_done
                       && (acc_cnt != '0);

   // Pop only in FILL, with credit left and the FIFO non-empty. A flush pulse
   // suppresses the pop in the same cycle so the flush sees a quiet pipeline.
   assign rd_en = !rst && !rd_empty && (state == FILL) && !flush
                  && (acc_sum < CNT_W'(RATIO));

   // NOTE: every variable assigned in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      acc_merged = acc;
      if (inflight) begin
         acc_merged[int'(acc_cnt)*WIDTH +: WIDTH] = rd_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         // NOTE: the packing register is reset (not left as don't-care) because
         // a partial beat ships its unused upper slots, which must read as zero.
         acc       <= '0;
         acc_cnt   <= '0;
         inflight  <= 1'b0;
         out_data  <= '0;
         out_cnt   <= '0;
         out_valid <= 1'b0;
      end else begin
         inflight <= rd_en;

         // Default: a consumed beat leaves the output empty unless a
         // replacement is loaded below on the same edge.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (group_done && out_free) begin
            // Full group (including a word captured on this edge) moves out.
            out_data  <= acc_merged;
            out_cnt   <= CNT_W'(RATIO);
            out_valid <= 1'b1;
            acc       <= '0;
            acc_cnt   <= '0;
         end else if (flush_emit) begin
            // inflight is zero here, so acc already holds every packed word.
            out_data  <= acc;
            out_cnt   <= acc_cnt;
            out_valid <= 1'b1;
            acc       <= '0;
            acc_cnt   <= '0;
         end else begin
            // Capture (or hold a completed group until the output frees).
            acc     <= acc_merged;
            acc_cnt <= acc_sum;
         end

         case (state)
            FILL: begin
               if (flush) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               // Leave once the pipeline is quiet and the output can accept a
               // partial beat; an empty accumulator simply returns to FILL.
               if (!inflight && out_free && !group_done) begin
                  state <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // Credit invariant: never more words claimed than one beat can hold.
   a_credit: assert property (@(posedge clk) disable iff (rst)
      (int'(acc_cnt) + int'(inflight)) <= RATIO);

   // The FIFO is never popped while it reports empty.
   a_no_empty_read: assert property (@(posedge clk) disable iff (rst)
      !(rd_en && rd_empty));

endmodule
